// File: rtl/satatrn_txdmaseq_if.sv
// Payload stream from the DMA buffer and data port toward the transport TX arbiter.
interface satatrn_txdmaseq_if;
  localparam int unsigned DW = 32;

  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic          o_txgate;

  modport master (
    input  s_valid, s_data, i_ready,
    output s_ready, o_valid, o_data, o_last, o_txgate
  );

  modport slave (
    output s_valid, s_data, i_ready,
    input  s_ready, o_valid, o_data, o_last, o_txgate
  );
endinterface

// File: rtl/satatrn_txdmaseq.sv
// Host-to-device DMA write sequencer: splits a command into Data FIS segments,
// paces each on a DMA Activate and tracks per-FIS link completion.
module satatrn_txdmaseq #(
  parameter int unsigned LGLEN    = 20,
  parameter int unsigned LGMAXFIS = 11
) (
  input  logic               i_phy_clk,
  input  logic               i_phy_reset_n,
  input  logic               i_abort,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [LGLEN-1:0]   i_cmd_len,
  input  logic               i_dma_activate,
  satatrn_txdmaseq_if.master bus,
  input  logic               i_link_done,
  input  logic               i_link_err,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [LGLEN-1:0]   o_remaining
);
  localparam int unsigned SEGW = LGMAXFIS + 1;
  localparam int unsigned GAPW = 2;
  localparam logic [LGLEN-1:0] MAXFIS_LEN = LGLEN'(1) << LGMAXFIS;
  localparam logic [SEGW-1:0]  MAXFIS_SEG = SEGW'(1) << LGMAXFIS;
  localparam logic [GAPW-1:0]  GAP_RELOAD = GAPW'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ACT,
    S_SEND,
    S_WAIT_DONE
  } state_t;

  state_t            state;
  logic              act_pend;
  logic [SEGW-1:0]   seg;
  logic [GAPW-1:0]   gap;
  logic [LGLEN-1:0]  remaining;
  logic              send;
  logic              hs;

  // Payload path is combinational while in SEND and fully gated otherwise
  assign send          = (state == S_SEND);
  assign hs            = send && bus.s_valid && bus.i_ready;
  assign o_cmd_ready   = (state == S_IDLE) && !i_abort;
  assign bus.o_txgate  = send;
  assign bus.o_valid   = send && bus.s_valid;
  assign bus.s_ready   = send && bus.i_ready;
  assign bus.o_data    = send ? bus.s_data : '0;
  assign bus.o_last    = send && (seg == SEGW'(1));
  assign o_busy        = (state != S_IDLE);
  assign o_remaining   = remaining;

  always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
    if (!i_phy_reset_n) begin
      state     <= S_IDLE;
      act_pend  <= 1'b0;
      seg       <= '0;
      gap       <= '0;
      remaining <= '0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      if (gap != '0) gap <= gap - GAPW'(1);
      if ((state != S_IDLE) && i_dma_activate) act_pend <= 1'b1;
      // A dword handed over in the abort cycle still counts as sent
      if (hs) begin
        seg       <= seg - SEGW'(1);
        remaining <= remaining - LGLEN'(1);
      end

      if (i_abort && (state != S_IDLE)) begin
        state    <= S_IDLE;
        o_err    <= 1'b1;
        act_pend <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_cmd_valid && o_cmd_ready) begin
              remaining <= i_cmd_len;
              if (i_cmd_len == '0) o_done <= 1'b1;
              else                 state  <= S_WAIT_ACT;
            end
          end
          S_WAIT_ACT: begin
            // Entry consumes the pending activate, including one arriving this cycle
            if (act_pend && (gap == '0)) begin
              state    <= S_SEND;
              act_pend <= 1'b0;
              seg      <= (remaining > MAXFIS_LEN) ? MAXFIS_SEG : SEGW'(remaining);
            end
          end
          S_SEND: begin
            if (hs && (seg == SEGW'(1))) begin
              state <= S_WAIT_DONE;
              gap   <= GAP_RELOAD;
            end
          end
          S_WAIT_DONE: begin
            if (i_link_err) begin
              o_err <= 1'b1;
              state <= S_IDLE;
            end else if (i_link_done) begin
              if (remaining == '0) begin
                o_done <= 1'b1;
                state  <= S_IDLE;
              end else begin
                state <= S_WAIT_ACT;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
